// File: rtl/apb_pkg.sv
// Shared APB definitions for the master and the slave memory block.
// Contents:
//   IDLE_ST / SETUP_ST / ACCESS_ST : 2-bit bus phase encodings
//   ADDR_W_DEF / DATA_W_DEF        : default address and data widths
package apb_pkg;

  localparam logic [1:0] IDLE_ST   = 2'b00;
  localparam logic [1:0] SETUP_ST  = 2'b01;
  localparam logic [1:0] ACCESS_ST = 2'b10;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/apb_master.sv
// APB requester: takes single read/write commands on a valid/ready port, runs
// IDLE -> SETUP -> ACCESS on the bus and returns a one-cycle response pulse.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command handshake (accepted in IDLE only)
//   rsp_valid/rdata/error/timeout    : completion pulse and held status
//   psel/penable/pwrite/paddr/pwdata : APB request outputs (all registered)
//   pready/pslverr/prdata            : APB slave inputs
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int unsigned CntW =
      (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Count value seen on the last permitted wait cycle; unused when the timeout is disabled.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic handshake;
  logic timeout_hit;

  assign cmd_ready   = (state_q == IDLE_ST) && !reset;
  assign handshake   = cmd_valid && cmd_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  // State register (also holds every registered output).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE_ST;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_ST:   if (handshake) state_d = SETUP_ST;
      SETUP_ST:  state_d = ACCESS_ST;
      ACCESS_ST: if (pready || timeout_hit) state_d = IDLE_ST;
      default:   state_d = IDLE_ST;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE_ST: begin
        if (handshake) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          cnt_d     = '0;
        end
      end
      SETUP_ST: penable_d = 1'b1;
      ACCESS_ST: begin
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;
  rsp_t sb[$];

  apb_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rdata=%h err=%b tmo=%b with empty scoreboard",
                 rsp_rdata, rsp_error, rsp_timeout);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
          errors++;
          $display("FAIL rsp_fields: got rdata=%h err=%b tmo=%b, want rdata=%h err=%b tmo=%b",
                   rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.tmo);
        end
      end
    end
  end

  // Issues one command and drives the slave; waits < 0 means pready never rises.
  // Returns at the negedge where rsp_valid is seen (or after the cycle budget).
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input logic err,
                         output int lat, output int setup_n, output int acc_n,
                         output bit stable, output bit got);
    int guard;
    lat = 0; setup_n = 0; acc_n = 0; stable = 1'b1; got = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    pready = 1'b0; pslverr = err; prdata = rd;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    @(negedge clock);
    // Junk on the command inputs must be ignored while busy.
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~wd;
    for (int i = 0; i < 40 && !got; i++) begin
      lat++;
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (psel === 1'b1 && penable === 1'b0) setup_n++;
        if (psel === 1'b1 && penable === 1'b1) begin
          acc_n++;
          if (waits >= 0 && acc_n == waits + 1) pready = 1'b1;
        end
        if (psel === 1'b1 && (paddr !== a || pwrite !== w || pwdata !== wd)) stable = 1'b0;
        @(negedge clock);
      end
    end
    pready = 1'b0;
    pslverr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_error, rsp_timeout} !== 6'b0 ||
        paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h, want 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    int lat, sn, an;
    bit st, got;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    do_xfer(1'b1, 32'd5, 32'hDEADBEEF, 0, 32'h1111_2222, 1'b0, lat, sn, an, st, got);
    checks++;
    if (!got || lat != 3 || sn != 1 || an != 1) begin
      errors++;
      $display("FAIL wr0_timing: got=%0d lat=%0d setup=%0d access=%0d, want 1 3 1 1",
               got, lat, sn, an);
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL wr0_bus_stable: paddr/pwrite/pwdata changed, want constant");
    end
    checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL wr0_rsp_cycle: cmd_ready=%b psel=%b pen=%b, want 1 0 0",
               cmd_ready, psel, penable);
    end
    checks++;
    if (pwdata !== 32'hDEADBEEF || paddr !== 32'd5) begin
      errors++;
      $display("FAIL wr0_hold: pwdata=%h paddr=%h, want deadbeef 5", pwdata, paddr);
    end
  endtask

  task automatic test_read_wait();
    int lat, sn, an;
    bit st, got;
    sb.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
    do_xfer(1'b0, 32'd5, 32'h0, 2, 32'hDEADBEEF, 1'b0, lat, sn, an, st, got);
    checks++;
    if (!got || lat != 5 || an != 3) begin
      errors++;
      $display("FAIL rd2_timing: got=%0d lat=%0d access=%0d, want 1 5 3", got, lat, an);
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL rd2_bus_stable: paddr/pwrite changed during transfer");
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd2_rsp_hold: rv=%b rdata=%h, want 0 deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_slave_error();
    int lat, sn, an;
    bit st, got;
    sb.push_back('{32'h0000_1234, 1'b1, 1'b0});
    do_xfer(1'b0, 32'd7, 32'h0, 0, 32'h0000_1234, 1'b1, lat, sn, an, st, got);
    checks++;
    if (!got || lat != 3) begin
      errors++;
      $display("FAIL slverr_timing: got=%0d lat=%0d, want 1 3", got, lat);
    end
  endtask

  task automatic test_timeout();
    int lat, sn, an;
    bit st, got;
    sb.push_back('{32'h0, 1'b1, 1'b1});
    do_xfer(1'b0, 32'd8, 32'h0, -1, 32'hCAFE_F00D, 1'b0, lat, sn, an, st, got);
    checks++;
    if (!got || lat != 6 || an != 4) begin
      errors++;
      $display("FAIL tmo_timing: got=%0d lat=%0d access=%0d, want 1 6 4", got, lat, an);
    end
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_bus_idle: psel=%b pen=%b cmd_ready=%b, want 0 0 1",
               psel, penable, cmd_ready);
    end
    sb.push_back('{32'h0, 1'b0, 1'b0});
    do_xfer(1'b1, 32'd9, 32'h0000_0099, 0, 32'h0, 1'b0, lat, sn, an, st, got);
    checks++;
    if (!got || lat != 3 || !st) begin
      errors++;
      $display("FAIL tmo_next_cmd: got=%0d lat=%0d stable=%0d, want 1 3 1", got, lat, st);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int acc_at[3];
    bit hs;
    n_acc = 0; hs = 1'b0;
    acc_at[0] = 0; acc_at[1] = 0; acc_at[2] = 0;
    @(negedge clock);
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_0055; cmd_write = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (hs) begin
        n_acc++;
        hs = 1'b0;
      end
      if (n_acc < 3) begin
        cmd_valid = 1'b1;
        cmd_addr  = n_acc;
        cmd_wdata = 32'd100 + n_acc;
      end else begin
        cmd_valid = 1'b0;
      end
      checks++;
      if (cmd_ready !== ~psel) begin
        errors++;
        $display("FAIL b2b_ready_idle: cycle %0d cmd_ready=%b psel=%b", i, cmd_ready, psel);
      end
      if (psel === 1'b1 && penable === 1'b0) begin
        checks++;
        if (paddr !== n_acc - 1 || pwdata !== 32'd99 + n_acc) begin
          errors++;
          $display("FAIL b2b_setup_addr: paddr=%h pwdata=%h, want %h %h",
                   paddr, pwdata, n_acc - 1, 32'd99 + n_acc);
        end
      end
      if (cmd_valid && cmd_ready === 1'b1 && n_acc < 3) begin
        hs = 1'b1;
        acc_at[n_acc] = i;
        sb.push_back('{32'h0, 1'b0, 1'b0});
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    pready = 1'b0;
    checks++;
    if (n_acc != 3 || acc_at[1] - acc_at[0] != 3 || acc_at[2] - acc_at[1] != 3) begin
      errors++;
      $display("FAIL b2b_spacing: accepted=%0d at %0d/%0d/%0d, want 3 at spacing 3",
               n_acc, acc_at[0], acc_at[1], acc_at[2]);
    end
  endtask

  task automatic test_reset_in_access();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3; pready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_access: psel=%b pen=%b, want 1 1", psel, penable);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        paddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_xfer: psel=%b pen=%b ready=%b rv=%b paddr=%h, want 0 0 0 0 0",
               psel, penable, cmd_ready, rsp_valid, paddr);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: ready=%b rv=%b psel=%b, want 1 0 0",
               cmd_ready, rsp_valid, psel);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_in_access();
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d responses missing, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
